// File: rtl/spi_byte_engine.sv
// Byte-serial SPI master: valid/ready byte in, SCLK/MOSI/MISO shift, rx strobe out.
// Also registers the SS pin and synchronizes the asynchronous INT pin.
module spi_byte_engine #(
    parameter int DIV_W = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             ss_en,
    output logic             int_sync,
    output logic             int_rise,
    output logic             SS,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO,
    input  logic             INT
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [3:0]       edge_q, edge_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic [7:0]       sh_q, sh_d;
    logic             mosi_q, mosi_d;
    logic             sclk_q, sclk_d;
    logic [7:0]       rxd_q, rxd_d;
    logic             rxv_q, rxv_d;
    logic             ss_q;
    logic             int_meta_q, int_sync_q, int_sync_d_q;

    logic [4:0] tog_n;
    logic       lead;
    logic       samp;
    logic       shift_mosi;
    logic [7:0] rx_next;

    // tog_n is the 1-based number of the toggle that would happen this cycle
    always_comb begin
        tog_n      = {1'b0, edge_q} + 5'd1;
        lead       = tog_n[0];
        samp       = cpha_q ? ~lead : lead;
        shift_mosi = cpha_q ? (lead && tog_n >= 5'd3)
                            : (~lead && tog_n <= 5'd14);
        rx_next    = {sh_q[6:0], MISO};
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        sh_d    = sh_q;
        mosi_d  = mosi_q;
        sclk_d  = sclk_q;
        rxd_d   = rxd_q;
        rxv_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                sclk_d = cpol;
                if (tx_valid) begin
                    state_d = SHIFT;
                    div_d   = div;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    sh_d    = tx_data;
                    mosi_d  = tx_data[7];
                    cnt_d   = div;
                    edge_d  = 4'd0;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else begin
                    cnt_d  = div_q;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 4'd1;
                    if (samp) sh_d = rx_next;
                    // sh_q[7] already holds the next tx bit after the prior sample
                    if (shift_mosi) mosi_d = sh_q[7];
                    if (tog_n[4]) begin
                        state_d = IDLE;
                        sclk_d  = cpol_q;
                        rxv_d   = 1'b1;
                        rxd_d   = samp ? rx_next : sh_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            edge_q  <= 4'd0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            sh_q    <= 8'h00;
            mosi_q  <= 1'b0;
            sclk_q  <= 1'b0;
            rxd_q   <= 8'h00;
            rxv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            sh_q    <= sh_d;
            mosi_q  <= mosi_d;
            sclk_q  <= sclk_d;
            rxd_q   <= rxd_d;
            rxv_q   <= rxv_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ss_q         <= 1'b1;
            int_meta_q   <= 1'b0;
            int_sync_q   <= 1'b0;
            int_sync_d_q <= 1'b0;
        end else begin
            ss_q         <= ~ss_en;
            int_meta_q   <= INT;
            int_sync_q   <= int_meta_q;
            int_sync_d_q <= int_sync_q;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q == SHIFT);
    assign rx_data  = rxd_q;
    assign rx_valid = rxv_q;
    assign SS       = ss_q;
    assign SCLK     = sclk_q;
    assign MOSI     = mosi_q;
    assign int_sync = int_sync_q;
    assign int_rise = int_sync_q & ~int_sync_d_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Scoreboard bench for spi_byte_engine: stimulus queues expected transfers,
// a negedge monitor checks SCLK timing, MOSI bits and received bytes.
module tb_spi_byte_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic [7:0] div = 8'd0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       ss_en = 1'b0;
    logic       int_sync;
    logic       int_rise;
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       int_i = 1'b0;

    spi_byte_engine #(.DIV_W(8)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .div(div), .cpol(cpol), .cpha(cpha), .ss_en(ss_en),
        .int_sync(int_sync), .int_rise(int_rise),
        .SS(ss), .SCLK(sclk), .MOSI(mosi), .MISO(miso), .INT(int_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         e0;
        logic [7:0] tx;
        logic [7:0] sl;
        bit         loop;
        int         dv;
        bit         pha;
    } xfer_t;

    typedef struct {
        logic [7:0] d;
        int         at;
    } rx_t;

    xfer_t      xq[$];
    rx_t        rxq[$];
    xfer_t      cur;
    bit         act = 1'b0;
    int         tog = 0;
    logic [7:0] sl = 8'h00;
    logic       sclk_prev;
    int         n_run = 0;
    int         n_fail = 0;

    assign miso = (act && cur.loop) ? mosi : sl[7];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: SCLK toggle timing, MOSI at sample edges, slave MISO, rx bytes
    always @(negedge clk) begin
        rx_t r;
        if (!act && xq.size() > 0 && cyc >= xq[0].e0) begin
            cur = xq.pop_front();
            act = 1'b1;
            tog = 0;
            sl  = cur.sl;
        end
        if (act && sclk !== sclk_prev) begin
            tog++;
            check("sclk_edge_time", cyc, cur.e0 + tog * (cur.dv + 1));
            if (cur.pha ? !tog[0] : tog[0])
                check("mosi_bit", {31'd0, mosi}, {31'd0, cur.tx[7 - (tog - 1) / 2]});
            if (cur.pha ? (tog[0] && tog >= 3) : (!tog[0] && tog <= 14))
                sl = {sl[6:0], 1'b0};
            if (tog == 16) act = 1'b0;
        end
        if (rx_valid) begin
            if (rxq.size() == 0) begin
                check("rx_unexpected", {31'd0, rx_valid}, 32'd0);
            end else begin
                r = rxq.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, r.d});
                check("rx_time", cyc, r.at);
            end
        end
        sclk_prev = sclk;
    end

    task automatic send(input logic [7:0] b, input logic [7:0] s,
                        input bit loop, input bit hold, output int e0);
        int    n;
        xfer_t x;
        rx_t   r;
        n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            check("accept_timeout", {31'd0, tx_ready}, 32'd1);
            tx_valid = 1'b0;
            e0 = -1;
            return;
        end
        e0     = cyc + 1;
        x.e0   = e0;
        x.tx   = b;
        x.sl   = s;
        x.loop = loop;
        x.dv   = int'(div);
        x.pha  = cpha;
        xq.push_back(x);
        r.d  = loop ? b : s;
        r.at = e0 + 16 * (int'(div) + 1);
        rxq.push_back(r);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((act || xq.size() > 0 || rxq.size() > 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            check("drain_act", {31'd0, act}, 32'd0);
            check("drain_rx", rxq.size(), 32'd0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int e1, e2, n, rises, first;

        repeat (3) @(negedge clk);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_ss", {31'd0, ss}, 32'd1);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_int_sync", {31'd0, int_sync}, 32'd0);
        check("rst_int_rise", {31'd0, int_rise}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // mode 0, div 3, loopback
        cpol = 1'b0; cpha = 1'b0; div = 8'd3;
        @(negedge clk);
        send(8'hA5, 8'h00, 1'b1, 1'b0, e1);
        check("busy_in_xfer", {31'd0, busy}, 32'd1);
        check("ready_in_xfer", {31'd0, tx_ready}, 32'd0);
        wait_idle();

        // mode 3, div 0, slave returns 0xC3
        cpol = 1'b1; cpha = 1'b1; div = 8'd0;
        repeat (2) @(negedge clk);
        check("sclk_idle_high", {31'd0, sclk}, 32'd1);
        send(8'h3C, 8'hC3, 1'b0, 1'b0, e1);
        wait_idle();
        check("sclk_idle_high_after", {31'd0, sclk}, 32'd1);

        // back-to-back, tx_valid held, div 1
        cpol = 1'b0; cpha = 1'b0; div = 8'd1;
        repeat (2) @(negedge clk);
        send(8'h01, 8'h7E, 1'b0, 1'b1, e1);
        send(8'h80, 8'h81, 1'b0, 1'b0, e2);
        check("b2b_accept", e2, e1 + 33);
        wait_idle();

        // div change mid-transfer
        div = 8'd2;
        @(negedge clk);
        send(8'h33, 8'hCC, 1'b0, 1'b0, e1);
        repeat (5) @(negedge clk);
        div = 8'd7;
        send(8'hE7, 8'h18, 1'b0, 1'b0, e2);
        check("div_change_accept", e2, e1 + 49);
        wait_idle();

        // reset at toggle 7 (mode 1, div 2)
        cpha = 1'b1; div = 8'd2; ss_en = 1'b1;
        repeat (2) @(negedge clk);
        check("ss_selected", {31'd0, ss}, 32'd0);
        send(8'h5A, 8'hA5, 1'b0, 1'b0, e1);
        n = 0;
        while (tog < 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_toggle7", {31'd0, (tog >= 7)}, 32'd1);
        #1 rst_n = 1'b0;
        act = 1'b0;
        xq.delete();
        rxq.delete();
        #1;
        check("mid_rst_ss", {31'd0, ss}, 32'd1);
        check("mid_rst_sclk", {31'd0, sclk}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
        check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        repeat (3) @(negedge clk);
        ss_en = 1'b0;
        rst_n = 1'b1;
        cpha = 1'b0; div = 8'd1;
        repeat (2) @(negedge clk);
        send(8'h96, 8'h69, 1'b0, 1'b0, e1);
        wait_idle();

        // INT synchronizer and rise pulse
        rises = 0;
        first = -1;
        int_i = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 5) int_i = 1'b0;
            if (int_rise) rises++;
            if (int_sync && first < 0) begin
                first = i;
                check("int_rise_with_sync", {31'd0, int_rise}, 32'd1);
            end
        end
        check("int_sync_latency", {31'd0, (first >= 2 && first <= 3)}, 32'd1);
        check("int_rise_count", rises, 32'd1);
        check("int_sync_low_after", {31'd0, int_sync}, 32'd0);

        // SS follows ~ss_en one cycle later
        ss_en = 1'b1;
        #1 check("ss_not_yet", {31'd0, ss}, 32'd1);
        @(negedge clk);
        check("ss_low", {31'd0, ss}, 32'd0);
        ss_en = 1'b0;
        @(negedge clk);
        check("ss_high", {31'd0, ss}, 32'd1);

        wait_idle();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
